// File: rtl/xcorr_pkg.sv
// Shared types and sizing helpers for the cross-correlation peak finder.
package xcorr_pkg;

    // Microphone pairs in the order the correlator emits them.
    typedef enum logic [2:0] {
        XC01 = 3'd0,
        XC02 = 3'd1,
        XC03 = 3'd2,
        XC12 = 3'd3,
        XC13 = 3'd4,
        XC23 = 3'd5
    } pair_e;

    localparam int NUM_XCORRS = 6;

    // Lag vector length for a given maximum sample delay.
    function automatic int numLags(input int maxSamplesDelay);
        return 2 * maxSamplesDelay + 1;
    endfunction

    // Width of a signed lag covering -maxSamplesDelay..+maxSamplesDelay.
    function automatic int numBitsLag(input int maxSamplesDelay);
        return $clog2(2 * maxSamplesDelay + 1) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/xcorr_peak_finder_if.sv
// Request/result bundle between the correlator, the peak finder and the TDOA stage.
interface xcorr_peak_finder_if
    import xcorr_pkg::*;
#(
    parameter int NUM_BITS_XCORR    = 31,
    parameter int MAX_SAMPLES_DELAY = 11
);
    localparam int NUM_LAGS     = numLags(MAX_SAMPLES_DELAY);
    localparam int NUM_BITS_LAG = numBitsLag(MAX_SAMPLES_DELAY);

    logic                                                    start;
    logic [NUM_XCORRS-1:0][NUM_LAGS-1:0][NUM_BITS_XCORR-1:0] xCorrIn;
    logic [NUM_BITS_XCORR-1:0]                               peakThreshold;
    logic                                                    busy;
    logic                                                    validOut;
    logic [NUM_XCORRS-1:0][NUM_BITS_LAG-1:0]                 lagOut;
    logic [NUM_XCORRS-1:0][NUM_BITS_XCORR-1:0]               peakOut;
    logic [NUM_XCORRS-1:0]                                   lagValid;

    modport master (
        output start, xCorrIn, peakThreshold,
        input  busy, validOut, lagOut, peakOut, lagValid
    );

    modport slave (
        input  start, xCorrIn, peakThreshold,
        output busy, validOut, lagOut, peakOut, lagValid
    );

endinterface

// File: rtl/xcorr_argmax_lane.sv
// Running signed maximum and its index for one pair's lag vector.
module xcorr_argmax_lane #(
    parameter int NUM_BITS_XCORR = 31,
    parameter int IDX_BITS       = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             first,
    input  logic [IDX_BITS-1:0]              idx,
    input  logic signed [NUM_BITS_XCORR-1:0] sample,
    output logic signed [NUM_BITS_XCORR-1:0] maxVal,
    output logic [IDX_BITS-1:0]              maxIdx
);

    // Load on the first lag, then replace only on strictly greater so ties keep the lowest index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            maxVal <= '0;
            maxIdx <= '0;
        end else if (en && (first || sample > maxVal)) begin
            maxVal <= sample;
            maxIdx <= idx;
        end
    end

endmodule

// File: rtl/xcorr_peak_finder.sv
// Snapshots the correlator lag vectors and scans them one lag per cycle, all pairs in parallel.
module xcorr_peak_finder
    import xcorr_pkg::*;
#(
    parameter int NUM_BITS_XCORR    = 31,
    parameter int MAX_SAMPLES_DELAY = 11
) (
    input logic               clk,
    input logic               rst,
    xcorr_peak_finder_if.slave bus
);

    localparam int NUM_LAGS     = numLags(MAX_SAMPLES_DELAY);
    localparam int NUM_BITS_LAG = numBitsLag(MAX_SAMPLES_DELAY);
    localparam int IDX_BITS     = $clog2(NUM_LAGS);
    localparam logic [IDX_BITS-1:0]     LAST_IDX = IDX_BITS'(NUM_LAGS - 1);
    localparam logic [NUM_BITS_LAG-1:0] LAG_OFS  = NUM_BITS_LAG'(MAX_SAMPLES_DELAY);

    state_e state, nextState;
    logic   capture, scanEn, doneLoad;

    logic [NUM_XCORRS-1:0][NUM_LAGS-1:0][NUM_BITS_XCORR-1:0] snap;
    logic signed [NUM_BITS_XCORR-1:0]                        threshSnap;
    logic [IDX_BITS-1:0]                                     k;

    logic signed [NUM_BITS_XCORR-1:0] laneMax [NUM_XCORRS];
    logic [IDX_BITS-1:0]              laneIdx [NUM_XCORRS];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Next-state and per-state control strobes.
    always_comb begin
        nextState = state;
        capture   = 1'b0;
        scanEn    = 1'b0;
        doneLoad  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    capture   = 1'b1;
                    nextState = SCAN;
                end
            end
            SCAN: begin
                scanEn = 1'b1;
                if (k == LAST_IDX) nextState = DONE;
            end
            DONE: begin
                doneLoad  = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    // Snapshot of inputs taken on the accepted start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            snap       <= '0;
            threshSnap <= '0;
        end else if (capture) begin
            snap       <= bus.xCorrIn;
            threshSnap <= bus.peakThreshold;
        end
    end

    // Lag index counter, walks 0..NUM_LAGS-1 during SCAN.
    always_ff @(posedge clk) begin
        if (!rst)                        k <= '0;
        else if (capture)                k <= '0;
        else if (scanEn && k != LAST_IDX) k <= k + 1'b1;
    end

    for (genvar p = 0; p < NUM_XCORRS; p++) begin : gLane
        xcorr_argmax_lane #(
            .NUM_BITS_XCORR(NUM_BITS_XCORR),
            .IDX_BITS      (IDX_BITS)
        ) uLane (
            .clk   (clk),
            .rst   (rst),
            .en    (scanEn),
            .first (k == '0),
            .idx   (k),
            .sample($signed(snap[p][k])),
            .maxVal(laneMax[p]),
            .maxIdx(laneIdx[p])
        );
    end

    // Result registers, updated once per search and held until the next one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.validOut <= 1'b0;
            bus.lagOut   <= '0;
            bus.peakOut  <= '0;
            bus.lagValid <= '0;
        end else begin
            bus.validOut <= doneLoad;
            if (doneLoad) begin
                for (int unsigned p = 0; p < NUM_XCORRS; p++) begin
                    bus.lagOut[p]   <= NUM_BITS_LAG'(laneIdx[p]) - LAG_OFS;
                    bus.peakOut[p]  <= laneMax[p];
                    bus.lagValid[p] <= (laneMax[p] >= threshSnap);
                end
            end
        end
    end

endmodule

// File: doc/xcorr_peak_finder.md
Name: xcorr_peak_finder

Overview:
- Consumes the cross-correlation lag vectors produced by the correlator: NUM_XCORRS pairs × (2·MAX_SAMPLES_DELAY+1) lags.
- On each accepted start, snapshots the vectors and scans them sequentially, one lag per cycle with all pairs in parallel.
- Reports per pair the argmax lag (signed sample delay), the peak value, and whether the peak meets a threshold.
- Feeds the downstream time-difference-of-arrival / direction estimator.

Parameters:
- NUM_BITS_XCORR, 31, width of each correlation value, two's complement signed.
- NUM_XCORRS, 6, number of microphone pairs, in order 01, 02, 03, 12, 13, 23.
- MAX_SAMPLES_DELAY, 11, maximum lag magnitude; lag vector length NUM_LAGS = 2·MAX_SAMPLES_DELAY+1.
- NUM_BITS_LAG, $clog2(2·MAX_SAMPLES_DELAY+1)+1 = 6, width of a signed lag output.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request a new peak search; sampled only in IDLE.
- xCorrIn  in  [NUM_XCORRS][NUM_LAGS][NUM_BITS_XCORR]  correlator output, signed.
- peakThreshold  in  NUM_BITS_XCORR  signed minimum peak for lagValid; captured with xCorrIn.
- busy  out  1  high in SCAN and DONE.
- validOut  out  1  one-cycle pulse when results update.
- lagOut  out  [NUM_XCORRS][NUM_BITS_LAG]  signed argmax lag per pair.
- peakOut  out  [NUM_XCORRS][NUM_BITS_XCORR]  signed peak value per pair.
- lagValid  out  [NUM_XCORRS]  peakOut[p] >= captured threshold.

Behaviour:
- Reset (rst=0 at a clock edge) forces the following, overriding any operation in progress including mid-SCAN:
  - state IDLE, busy=0, validOut=0;
  - lagOut, peakOut and lagValid all 0;
  - snapshot and scan registers cleared.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: when start=1, register xCorrIn and peakThreshold into the snapshot, set lag index k=0, go to SCAN. When start=0, stay in IDLE.
  - SCAN: each cycle, every pair lane compares snap[p][k] with its running max.
    - At k=0 the lane loads unconditionally.
    - For k>0 it replaces only if strictly greater (signed compare), so ties resolve to the lowest index.
    - After k=NUM_LAGS-1, go to DONE.
  - DONE: register results into lagOut, peakOut and lagValid; validOut=1 for this cycle only; go to IDLE.
- start is ignored while busy; there is no queueing.
- start arriving in the same cycle the FSM returns to IDLE is ignored; it is sampled on the next IDLE cycle.
- Snapshot isolation: xCorrIn may change freely after the capture cycle without affecting the result.
- Lag mapping: lag = k − MAX_SAMPLES_DELAY, range −11..+11. Index 0 → −11, index 11 → 0, index 22 → +11.
- Latency: start accepted at edge 0; the SCAN phase lasts NUM_LAGS cycles; validOut is high in the cycle after edge NUM_LAGS+1, i.e. 24 cycles after acceptance at default parameters. The next start can be accepted one cycle after validOut.
- Outputs hold their last values between validOut pulses.
- Arithmetic: all compares are signed at full NUM_BITS_XCORR; no truncation or saturation. The lag index is an unsigned counter of $clog2(NUM_LAGS) bits; the subtraction is done at NUM_BITS_LAG signed.
- All-negative vectors are legal; the peak is the least-negative value.

Decomposition:
- xcorr_pkg holds:
  - the pair enum (XC01..XC23 = 0..5);
  - NUM_XCORRS;
  - a function computing NUM_LAGS and NUM_BITS_LAG from MAX_SAMPLES_DELAY;
  - the FSM state typedef.
- One sub-module, xcorr_argmax_lane:
  - one instance per pair;
  - inputs: the current sample, first-flag and enable;
  - outputs: the running max value and the index of the max;
  - the top level holds the FSM, snapshot, counter and output registers.

Test Plan:
- Single peak: pair 0 has value 1000 at index 14 and 0 elsewhere; pulse start → validOut exactly 24 cycles later. Pair 0 reports lagOut=+3, peakOut=1000, lagValid=1 with threshold 500; other pairs report lagOut=−11 and peakOut=0.
- Ties and negatives:
  - pair 1 has −5 everywhere except −2 at indices 4 and 9 → lagOut=−7, peakOut=−2;
  - pair 2 has the max positive value 2^30−1 at index 22 → lag=+11;
  - with threshold 0, pair 1 gives lagValid=0.
- Snapshot isolation: change xCorrIn every cycle during SCAN → results match the vectors present at the start edge.
- Busy gating: hold start=1 continuously → exactly one validOut per 25 cycles, and busy is high for 24 of every 25 cycles.
- Reset mid-scan: drive rst=0 at scan cycle 10 → the next edge gives busy=0 and all outputs 0, with no validOut. After release, a new start completes normally.
- Back-to-back: two searches with different vectors → the second validOut carries only the second set of results, and outputs are stable between the pulses.
